load_store_unit: RTL
====================

# load_store_unit

Memory-access stage of the RV32I core. It sits between execute and `write_back`: it takes the ALU-computed address, store data and load/store controls, and runs a request/acknowledge transaction on the data-memory bus. It returns a sign- or zero-extended load result as `data_mem_out` to the write-back mux, and stalls the core while a bus transaction is outstanding.

## Interface

**Parameters**
- `ADDR_W`, default 32, byte-address width driven on `mem_addr`.

**Ports**
- `clk` input 1: single core clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mem_read` input 1: current instruction is a load.
- `mem_write` input 1: current instruction is a store.
- `funct3` input 3: access type. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `alu_out` input 32: effective byte address.
- `rs2_data` input 32: store data.
- `stall` output 1: hold the PC and all architectural state this cycle.
- `data_mem_out` output 32: extended load result, to `write_back`.
- `access_err` output 1: one-cycle pulse flagging a misaligned, illegal-funct3 or read+write access.
- `mem_req` output 1: bus request, registered.
- `mem_we` output 1: 1 = write, registered.
- `mem_addr` output ADDR_W: word-aligned address (`alu_out[ADDR_W-1:2]`, 2'b00), registered.
- `mem_wdata` output 32: lane-replicated store data, registered.
- `mem_wmask` output 4: byte enables, registered; 0000 on reads.
- `mem_rdata` input 32: read word; valid only while `mem_ack` = 1.
- `mem_ack` input 1: completes the outstanding request.

## Operation

**States:** IDLE, REQ, DONE.

**IDLE**
- An access is `mem_read` | `mem_write`.
- Error conditions (no bus activity):
  - `mem_read` and `mem_write` both high.
  - funct3 not legal for the access direction.
  - LH/LHU/SH with `addr[0]` = 1.
  - LW/SW with `addr[1:0]` ≠ 0.
- On error: `access_err` = 1 combinationally, `stall` = 0, stay in IDLE. `data_mem_out` is unchanged.
- On a valid access: `stall` = 1. Register the bus fields, set `mem_req` = 1 and go to REQ.
- No access: `stall` = 0.

**REQ**
- `stall` = 1. `mem_req` and all bus fields stay stable until `mem_ack`.
- On `mem_ack`: `mem_req` drops next edge, and the state goes to DONE.
- On a load, the load result is latched into `data_mem_out` on the same edge.

**DONE**
- `stall` = 0 for exactly one cycle; the core commits the instruction this cycle.
- Next state is always IDLE, and the next instruction is evaluated there.

**Store lane formatting**
- SB: `wdata` = {4{rs2[7:0]}}, `wmask` = 0001 << addr[1:0].
- SH: `wdata` = {2{rs2[15:0]}}, `wmask` = 0011 << addr[1:0].
- SW: `wdata` = rs2, `wmask` = 1111.

**Load extraction**
- The byte/half is selected by `addr[1:0]` from `mem_rdata`.
- LB/LH: sign-extended. LBU/LHU: zero-extended. LW: full word.

**Other rules**
- Stores never modify `data_mem_out`. It holds its last load value.
- `mem_ack` outside REQ is ignored.

## Timing

- Reset values: state IDLE; `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `data_mem_out` = 0; `mem_wmask` = 0000. Consequently `stall` = 0 and `access_err` = 0.
- Access latency: issue cycle (IDLE, stall) → REQ for ≥ 1 cycle → DONE.
  - With `mem_ack` in the first REQ cycle, the instruction takes 3 cycles and `stall` is high for 2.
  - Each extra wait cycle adds one.
- The `mem_ack` sample edge, `data_mem_out` update and REQ → DONE transition all occur on the same edge.
- `rst` during REQ: `mem_req` is 0 from the next edge, and a late `mem_ack` is ignored.
- `rst` during DONE: the latched `data_mem_out` is cleared to 0.
- Inputs are held constant by the core while `stall` = 1. The unit samples them only in IDLE.

## Test plan

- **LW aligned.** `alu_out` = 0x100, `mem_ack` in the first REQ cycle with `mem_rdata` = 0xDEADBEEF.
  - `mem_req` high 1 cycle, `mem_addr` = 0x100, `mem_wmask` = 0000.
  - `data_mem_out` = 0xDEADBEEF in DONE; `stall` pattern 1,1,0.
- **LB/LBU lane select.** `alu_out` = 0x103, `mem_rdata` = 0x80112233.
  - LB → 0xFFFFFF80; LBU → 0x00000080.
  - LHU at 0x102 → 0x00008011.
- **SB/SH formatting.**
  - SB at 0x201 with `rs2` = 0x123456AB → `mem_wdata` = 0xABABABAB, `mem_wmask` = 0010, `mem_we` = 1.
  - SH at 0x202 → `mem_wmask` = 1100.
  - `data_mem_out` is unchanged by either store.
- **Wait states.** `mem_ack` delayed 4 cycles.
  - `mem_req` and the bus fields stay stable for all 4 cycles.
  - `stall` is high for 5 cycles, then low for 1 (DONE).
- **Errors.** Each case must give an `access_err` pulse, `stall` = 0 and `mem_req` never asserted:
  - LW at 0x102.
  - SH at 0x001.
  - funct3 = 011 load.
  - `mem_read` and `mem_write` both high.
- **Reset mid-transaction.** Assert `rst` in the 2nd REQ cycle, then pulse `mem_ack` one cycle later.
  - State is IDLE, `mem_req` = 0, `data_mem_out` = 0.
  - The late ack causes no transition.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: issues one request/acknowledge bus transaction per
// load or store, formats store lanes and sign/zero-extends load results.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       rs2_data,
    output logic              stall,
    output logic [31:0]       data_mem_out,
    output logic              access_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [31:0]       dout_q, dout_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        lane_q, lane_d;

    logic              access;
    logic              ld_f3_ok;
    logic              st_f3_ok;
    logic              misaligned;
    logic              illegal;
    logic [ADDR_W-1:0] addr_word;
    logic [31:0]       st_wdata;
    logic [3:0]        st_wmask;
    logic [31:0]       rd_shifted;
    logic [31:0]       ld_result;

    if (ADDR_W > 32) begin : g_addr_wide
        assign addr_word = {{(ADDR_W-32){1'b0}}, alu_out[31:2], 2'b00};
    end else begin : g_addr_narrow
        assign addr_word = {alu_out[ADDR_W-1:2], 2'b00};
    end

    // Access legality, evaluated only while IDLE
    always_comb begin
        access   = mem_read | mem_write;
        ld_f3_ok = 1'b0;
        st_f3_ok = 1'b0;
        unique case (funct3)
            3'b000, 3'b001, 3'b010: begin
                ld_f3_ok = 1'b1;
                st_f3_ok = 1'b1;
            end
            3'b100, 3'b101: ld_f3_ok = 1'b1;
            default: ;
        endcase
        misaligned = ((funct3[1:0] == 2'b01) && alu_out[0])
                   || ((funct3[1:0] == 2'b10) && (alu_out[1:0] != 2'b00));
        illegal = (mem_read && mem_write)
                || (mem_read && !ld_f3_ok)
                || (mem_write && !st_f3_ok)
                || misaligned;
    end

    always_comb begin
        st_wdata = rs2_data;
        st_wmask = 4'b1111;
        unique case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{rs2_data[7:0]}};
                st_wmask = 4'b0001 << alu_out[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2_data[15:0]}};
                st_wmask = 4'b0011 << alu_out[1:0];
            end
            default: ;
        endcase
    end

    // Lane and extension come from values captured at issue, not live inputs
    always_comb begin
        rd_shifted = mem_rdata >> {lane_q, 3'b000};
        unique case (ld_f3_q)
            3'b000:  ld_result = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  ld_result = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  ld_result = {24'h000000, rd_shifted[7:0]};
            3'b101:  ld_result = {16'h0000, rd_shifted[15:0]};
            default: ld_result = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        dout_d     = dout_q;
        ld_f3_d    = ld_f3_q;
        lane_d     = lane_q;
        stall      = 1'b0;
        access_err = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (illegal) begin
                        access_err = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = addr_word;
                        wdata_d = mem_write ? st_wdata : '0;
                        wmask_d = mem_write ? st_wmask : '0;
                        ld_f3_d = funct3;
                        lane_d  = alu_out[1:0];
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        dout_d = ld_result;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            dout_q  <= '0;
            ld_f3_q <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            dout_q  <= dout_d;
            ld_f3_q <= ld_f3_d;
            lane_q  <= lane_d;
        end
    end

    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wmask    = wmask_q;
    assign data_mem_out = dout_q;

endmodule
